// File: rtl/regfile_pkg.sv
// Shared widths and requester indices for the register-file write-back arbiter.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = 5'd31;

  localparam int NUM_REQ = 3;
  localparam logic [1:0] REQ_ALU  = 2'd0;
  localparam logic [1:0] REQ_MEM  = 2'd1;
  localparam logic [1:0] REQ_LINK = 2'd2;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Three-way round-robin arbiter: the search starts at ptr_q, and the pointer
// moves to the slot after the winner. With no grant, the pointer holds.
module rr_arbiter3
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  logic [1:0] ptr_q, ptr_d;

  // Rotated priority search, then advance the pointer past the winner
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    case (ptr_q)
      REQ_MEM: begin
        if      (valid[REQ_MEM])  grant[REQ_MEM]  = 1'b1;
        else if (valid[REQ_LINK]) grant[REQ_LINK] = 1'b1;
        else if (valid[REQ_ALU])  grant[REQ_ALU]  = 1'b1;
      end
      REQ_LINK: begin
        if      (valid[REQ_LINK]) grant[REQ_LINK] = 1'b1;
        else if (valid[REQ_ALU])  grant[REQ_ALU]  = 1'b1;
        else if (valid[REQ_MEM])  grant[REQ_MEM]  = 1'b1;
      end
      default: begin
        if      (valid[REQ_ALU])  grant[REQ_ALU]  = 1'b1;
        else if (valid[REQ_MEM])  grant[REQ_MEM]  = 1'b1;
        else if (valid[REQ_LINK]) grant[REQ_LINK] = 1'b1;
      end
    endcase
    if      (grant[REQ_ALU])  ptr_d = REQ_MEM;
    else if (grant[REQ_MEM])  ptr_d = REQ_LINK;
    else if (grant[REQ_LINK]) ptr_d = REQ_ALU;
  end

  // Pointer register, starts at the ALU after reset
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= REQ_ALU;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: ALU, load and
// link requesters share it round-robin, through a one-cycle registered
// write stage. It also keeps the pending-write scoreboard used for RAW stalls.
// The optional macro WB_BYPASS_EN adds two compare ports that expose the write
// landing in the current cycle to read-port consumers.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                link_valid,
  input  logic [DATA_W-1:0]   link_data,
  output logic                link_ready,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic [NUM_REGS-1:0] pending,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]   byp_addr1,
  input  logic [ADDR_W-1:0]   byp_addr2,
  output logic                byp_hit1,
  output logic                byp_hit2,
  output logic [DATA_W-1:0]   byp_data1,
  output logic [DATA_W-1:0]   byp_data2,
`endif
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data
);

  logic [NUM_REQ-1:0]  req_vld, grant;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Requests are masked during reset, so no ready rises and nothing is granted
  assign req_vld = {link_valid, mem_valid, alu_valid} & {NUM_REQ{~rst}};

  rr_arbiter3 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_vld),
    .grant (grant)
  );

  assign alu_ready  = grant[REQ_ALU];
  assign mem_ready  = grant[REQ_MEM];
  assign link_ready = grant[REQ_LINK];

  // Load the winner into the write stage; clear its scoreboard bit, and let
  // a same-cycle issue set the bit again because that writer is newer
  always_comb begin
    wr_en_d   = |grant;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pending_d = pending_q;
    if (grant[REQ_ALU]) begin
      wr_addr_d = alu_dest;
      wr_data_d = alu_data;
    end else if (grant[REQ_MEM]) begin
      wr_addr_d = mem_dest;
      wr_data_d = mem_data;
    end else if (grant[REQ_LINK]) begin
      wr_addr_d = LINK_ADDR;
      wr_data_d = link_data;
    end
    if (wr_en_d)  pending_d[wr_addr_d]  = 1'b0;
    if (issue_en) pending_d[issue_dest] = 1'b1;
  end

  // Write stage and scoreboard registers; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;

`ifdef WB_BYPASS_EN
  assign byp_hit1  = wr_en_q & (wr_addr_q == byp_addr1);
  assign byp_hit2  = wr_en_q & (wr_addr_q == byp_addr2);
  assign byp_data1 = wr_data_q;
  assign byp_data2 = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1ns after the rising
// edge, readys are sampled 1ns later, and registered outputs 1ns after an edge.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                alu_valid, mem_valid, link_valid, issue_en;
  logic [ADDR_W-1:0]   alu_dest, mem_dest, issue_dest;
  logic [DATA_W-1:0]   alu_data, mem_data, link_data;
  logic                alu_ready, mem_ready, link_ready;
  logic [NUM_REGS-1:0] pending;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0]   byp_addr1, byp_addr2;
  logic                byp_hit1, byp_hit2;
  logic [DATA_W-1:0]   byp_data1, byp_data2;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_dest   (alu_dest),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_dest   (mem_dest),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .link_valid (link_valid),
    .link_data  (link_data),
    .link_ready (link_ready),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .pending    (pending),
`ifdef WB_BYPASS_EN
    .byp_addr1  (byp_addr1),
    .byp_addr2  (byp_addr2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_data1  (byp_data1),
    .byp_data2  (byp_data2),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; link_valid = 0; issue_en = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // expected grant per cycle for the fairness run: 1=MEM, 2=LINK
  int fair_exp [6] = '{1, 2, 1, 2, 1, 2};

  initial begin
    rst = 1; idle();
    alu_dest = 0; mem_dest = 0; issue_dest = 0;
    alu_data = 0; mem_data = 0; link_data = 0;
`ifdef WB_BYPASS_EN
    byp_addr1 = 0; byp_addr2 = 0;
`endif

    // Reset: requests and an issue during reset are ignored
    alu_valid = 1; alu_dest = 5'd2; alu_data = 32'h11;
    issue_en = 1; issue_dest = 5'd2;
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    tick(); tick();
    chk("rst_wr_en",   64'(wr_en),   64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    idle(); rst = 0;

    // Reset mid-write: ALU r5 granted with an issue to r10, then reset
    alu_valid = 1; alu_dest = 5'd5; alu_data = 32'hA5;
    issue_en = 1; issue_dest = 5'd10;
    #1;
    chk("midrst_ready", 64'(alu_ready), 64'd1);
    tick();
    idle(); rst = 1;
    chk("midrst_pend_pre", 64'(pending), 64'(32'h0000_0400));
    tick();
    rst = 0;
    chk("midrst_wr_en",   64'(wr_en),   64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);

    // Single ALU write: one-cycle latency, single pulse
    alu_valid = 1; alu_dest = 5'd3; alu_data = 32'h1234;
    #1;
    chk("single_ready", 64'(alu_ready), 64'd1);
    chk("single_mready", 64'(mem_ready), 64'd0);
    tick();
    alu_valid = 0;
    chk("single_wr_en",   64'(wr_en),   64'd1);
    chk("single_wr_addr", 64'(wr_addr), 64'd3);
    chk("single_wr_data", 64'(wr_data), 64'h1234);
    tick();
    chk("single_wr_off",  64'(wr_en),   64'd0);

    // All three valid from reset: ALU, MEM, LINK, continuous wr_en
    do_reset();
    alu_valid = 1; alu_dest = 5'd4; alu_data = 32'hA0;
    mem_valid = 1; mem_dest = 5'd6; mem_data = 32'hB0;
    link_valid = 1; link_data = 32'hC0;
    #1;
    chk("all_c0_grant", 64'({link_ready, mem_ready, alu_ready}), 64'b001);
    tick();
    chk("all_c0_addr", 64'(wr_addr), 64'd4);
    chk("all_c0_data", 64'(wr_data), 64'hA0);
    chk("all_c1_grant", 64'({link_ready, mem_ready, alu_ready}), 64'b010);
    tick();
    chk("all_c1_en",   64'(wr_en),   64'd1);
    chk("all_c1_addr", 64'(wr_addr), 64'd6);
    chk("all_c2_grant", 64'({link_ready, mem_ready, alu_ready}), 64'b100);
    tick();
    idle();
    chk("all_c2_en",   64'(wr_en),   64'd1);
    chk("all_c2_addr", 64'(wr_addr), 64'd31);
    chk("all_c2_data", 64'(wr_data), 64'hC0);
    tick();
    chk("all_end_en",  64'(wr_en),   64'd0);

    // Fairness: MEM and LINK held valid alternate (pointer is back at ALU)
    mem_valid = 1; mem_dest = 5'd8; mem_data = 32'h88;
    link_valid = 1; link_data = 32'h77;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("fair_grant%0d", i), 64'({link_ready, mem_ready}), 64'(fair_exp[i]));
      tick();
      chk($sformatf("fair_addr%0d", i), 64'(wr_addr), (fair_exp[i] == 1) ? 64'd8 : 64'd31);
    end
    idle();
    tick();

    // Scoreboard: set, set-wins over clear, later clear
    issue_en = 1; issue_dest = 5'd7;
    tick();
    issue_en = 0;
    chk("sb_set7", 64'(pending), 64'(32'h0000_0080));
    mem_valid = 1; mem_dest = 5'd7; mem_data = 32'h70;
    issue_en = 1; issue_dest = 5'd7;
    tick();
    idle();
    chk("sb_setwins", 64'(pending), 64'(32'h0000_0080));
    mem_valid = 1;
    tick();
    idle();
    chk("sb_clear7", 64'(pending), 64'd0);
    // Link clears r31, r0 is scoreboarded like any other register
    issue_en = 1; issue_dest = 5'd31;
    tick();
    issue_dest = 5'd0;
    tick();
    issue_en = 0;
    chk("sb_set31_0", 64'(pending), 64'(32'h8000_0001));
    link_valid = 1; link_data = 32'h400;
    tick();
    idle();
    chk("sb_link_clr", 64'(pending), 64'(32'h0000_0001));
    alu_valid = 1; alu_dest = 5'd0; alu_data = 32'h5;
    tick();
    idle();
    chk("sb_r0_clr",  64'(pending), 64'd0);
    chk("sb_r0_addr", 64'(wr_addr), 64'd0);
    chk("sb_r0_data", 64'(wr_data), 64'h5);

`ifdef WB_BYPASS_EN
    alu_valid = 1; alu_dest = 5'd9; alu_data = 32'hDEAD;
    tick();
    idle();
    byp_addr1 = 5'd9; byp_addr2 = 5'd4;
    #1;
    chk("byp_hit1",  64'(byp_hit1),  64'd1);
    chk("byp_data1", 64'(byp_data1), 64'hDEAD);
    chk("byp_hit2",  64'(byp_hit2),  64'd0);
    tick();
    chk("byp_hit1_off", 64'(byp_hit1), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between three write-back requesters: ALU result, memory load, and branch-link (return address into r31).
- Round-robin arbitration with a registered write stage.
- Keeps a 32-bit pending-write scoreboard so the issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and register_file; its wr_* outputs drive the register file's write side.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- LINK_ADDR, 31, destination used for link requests

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU write-back request
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load write-back request
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- link_valid  in  1  link write request (destination fixed to LINK_ADDR)
- link_data  in  DATA_W  return address
- link_ready  out  1  link request accepted this cycle
- issue_en  in  1  an instruction with a register destination issues this cycle
- issue_dest  in  ADDR_W  destination of the issuing instruction
- pending  out  32  scoreboard; bit i set means a write to ri is outstanding
- wr_en  out  1  register-file write strobe
- wr_addr  out  ADDR_W  register-file write address
- wr_data  out  DATA_W  register-file write data

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_en=0, wr_addr=0, wr_data=0, pending=0.
  - RR pointer points at ALU.
  - All readys are 0 while rst=1.
  - Any in-flight write stage is discarded and not written.
  - An issue presented in the reset cycle is dropped.
- Handshake:
  - A transfer occurs when valid & ready are both high at a clk edge.
  - ready is combinational from the valids and the RR pointer.
  - At most one ready is high per cycle.
  - A requester holds valid, dest and data stable until accepted.
- Arbitration:
  - Order is ALU(0), MEM(1), LINK(2).
  - Search starts at the RR pointer; the first valid requester wins.
  - After a grant, the pointer moves to winner+1 (mod 3).
  - With no grant, the pointer holds.
  - Worst-case wait is 2 cycles for a continuously valid requester.
- Write stage:
  - A grant at edge N makes wr_en=1 with the winner's dest/data (LINK_ADDR for link) during cycle N+1; latency is 1 cycle.
  - wr_en is a single-cycle pulse per grant.
  - Back-to-back grants give a continuous wr_en, one write per cycle.
  - No backpressure from the register file.
- Scoreboard:
  - issue_en sets pending[issue_dest].
  - A grant clears pending[dest] at the same edge the write stage loads.
  - Set and clear of the same bit in the same cycle: set wins, because a newer writer is outstanding.
  - Link requests clear bit LINK_ADDR.
  - Two outstanding writes to one register keep the bit set until the later issue's write; the issue unit must not issue a second writer to a pending register, and the block does not check this.
  - r0 is an ordinary register (no hardwired zero): it may be written and scoreboarded.
- Simultaneous events:
  - All three valid: exactly one is granted.
  - Issue, grant and reset in the same cycle: reset dominates.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined:
  - Adds inputs byp_addr1/byp_addr2 (ADDR_W).
  - Adds outputs byp_hit1/byp_hit2 (1) and byp_data1/byp_data2 (DATA_W).
  - byp_hitK = wr_en & (wr_addr == byp_addrK), combinational; byp_dataK = wr_data.
  - Lets read-port consumers see a write landing in the same cycle.
- When undefined:
  - These ports are absent.
  - Consumers wait one extra cycle, until the register file has been updated.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, LINK_ADDR
  - requester index constants REQ_ALU=0, REQ_MEM=1, REQ_LINK=2, NUM_REQ=3
- Sub-module rr_arbiter3: pointer register plus grant one-hot, takes a valid vector and returns a grant vector.
- Scoreboard and write stage stay in the top module.

Test Plan:
- Reset mid-write: grant ALU dest=5 data=0xA5, assert rst on the next edge -> wr_en=0, pending=0, no write to r5.
- Single ALU: alu_valid dest=3 data=0x1234 -> alu_ready same cycle; next cycle wr_en=1, wr_addr=3, wr_data=0x1234; following cycle wr_en=0.
- All three valid for 3 cycles from reset -> grant order ALU, MEM, LINK; wr_addr sequence alu_dest, mem_dest, 31; wr_en high for 3 consecutive cycles.
- Fairness: MEM and LINK held valid for 6 cycles -> grants alternate MEM, LINK, MEM, LINK, MEM, LINK.
- Scoreboard: issue dest=7 -> pending[7]=1; in the cycle a mem grant for dest=7 coincides with issue dest=7 -> pending[7] stays 1; a later grant for dest 7 -> pending[7]=0.
- WB_BYPASS_EN: write r9=0xDEAD in the write stage with byp_addr1=9, byp_addr2=4 -> byp_hit1=1, byp_data1=0xDEAD, byp_hit2=0.
